// File: rtl/cache_miss_controller.sv
// rtl/cache_miss_controller.sv - access sequencer between CPU port, 2-line L1 cache and RAM
//
// Purpose: write-back / write-allocate miss handling for a fully associative
// 2-line cache. The cache and RAM arrays live outside; this block issues their
// strobes and consumes lookup/victim/read results.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   cpu_*                request (write/addr/wdata) in; ready/rdata/hit out
//   busy                 controller not idle
//   cache_lookup, cache_hit/_hit_way/_rdata, victim_*    lookup handshake
//   cache_fill, fill_way/_tag/_data/_dirty               line write strobe
//   ram_req/_write/_addr/_wdata, ram_ack/_rdata          RAM handshake
//   err                  sticky RAM timeout flag
//   hit_count, miss_count  saturating completion counters
module cache_miss_controller #(
  parameter int RAM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_write,
  input  logic [7:0]       cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_ready,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_hit,
  output logic             busy,
  output logic             cache_lookup,
  input  logic             cache_hit,
  input  logic             cache_hit_way,
  input  logic [7:0]       cache_rdata,
  input  logic             victim_way,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  input  logic [7:0]       victim_tag,
  input  logic [7:0]       victim_data,
  output logic             cache_fill,
  output logic             fill_way,
  output logic [7:0]       fill_tag,
  output logic [7:0]       fill_data,
  output logic             fill_dirty,
  output logic             ram_req,
  output logic             ram_write,
  output logic [7:0]       ram_addr,
  output logic [7:0]       ram_wdata,
  input  logic             ram_ack,
  input  logic [7:0]       ram_rdata,
  output logic             err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FETCH, S_FILL, S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(RAM_TIMEOUT - 1);

  state_t     state, next_state;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       hit_r;
  logic       way_r;
  logic [7:0] tcnt;
  logic       timed_out;
  logic       done_hit;
  logic       lookup_way;

  always_comb begin
    next_state = state;
    timed_out  = 1'b0;
    done_hit   = 1'b0;
    lookup_way = cache_hit ? cache_hit_way : victim_way;
    case (state)
      S_IDLE: if (cpu_req) next_state = S_LOOKUP;
      S_LOOKUP: begin
        done_hit = cache_hit;
        if (cache_hit)                        next_state = req_write ? S_FILL : S_DONE;
        else if (victim_valid && victim_dirty) next_state = S_WB;
        else                                   next_state = req_write ? S_FILL : S_FETCH;
      end
      S_WB: begin
        // an ack on the limit cycle still counts as a normal completion
        if (ram_ack) next_state = req_write ? S_FILL : S_FETCH;
        else if (tcnt == TMO_LAST) begin
          timed_out  = 1'b1;
          next_state = S_DONE;
        end
      end
      S_FETCH: begin
        if (ram_ack) next_state = S_FILL;
        else if (tcnt == TMO_LAST) begin
          timed_out  = 1'b1;
          next_state = S_DONE;
        end
      end
      S_FILL: begin
        done_hit   = hit_r;
        next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes and RAM outputs are registered from next_state so they are
  // glitch-free and aligned with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      cache_lookup <= 1'b0;
      cache_fill   <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      cpu_hit      <= 1'b0;
      fill_way     <= 1'b0;
      fill_tag     <= '0;
      fill_data    <= '0;
      fill_dirty   <= 1'b0;
      ram_req      <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      err          <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      req_write    <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      hit_r        <= 1'b0;
      way_r        <= 1'b0;
      tcnt         <= '0;
    end else begin
      state        <= next_state;
      busy         <= (next_state != S_IDLE);
      cache_lookup <= (next_state == S_LOOKUP);
      cache_fill   <= (next_state == S_FILL);
      cpu_ready    <= (next_state == S_DONE);
      ram_req      <= (next_state == S_WB) || (next_state == S_FETCH);
      cpu_hit      <= 1'b0;

      if (state == S_IDLE && cpu_req) begin
        req_write <= cpu_write;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end

      if (state == S_LOOKUP) begin
        hit_r <= cache_hit;
        way_r <= lookup_way;
        if (cache_hit && !req_write) cpu_rdata <= cache_rdata;
      end

      if ((state == S_WB || state == S_FETCH) && next_state == state)
        tcnt <= tcnt + 8'd1;

      if (timed_out) err <= 1'b1;

      if (next_state != state) begin
        case (next_state)
          S_WB: begin
            // ram_addr/ram_wdata double as the latched victim tag/data
            tcnt      <= '0;
            ram_write <= 1'b1;
            ram_addr  <= victim_tag;
            ram_wdata <= victim_data;
          end
          S_FETCH: begin
            tcnt      <= '0;
            ram_write <= 1'b0;
            ram_addr  <= req_addr;
          end
          S_FILL: begin
            fill_way   <= (state == S_LOOKUP) ? lookup_way : way_r;
            fill_tag   <= req_addr;
            fill_data  <= req_write ? req_wdata : ram_rdata;
            fill_dirty <= req_write;
            if (!req_write) cpu_rdata <= ram_rdata;
          end
          S_DONE: begin
            cpu_hit <= done_hit;
            if (timed_out) cpu_rdata <= '0;
            if (done_hit) begin
              if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
              if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
- FSM between the CPU-side request port, the 2-line fully associative L1 cache and the RAM.
- Sequences every access: lookup, dirty-victim write-back, line fetch, fill, completion.
- Cache and RAM arrays stay outside this block. It only drives their control and data strobes and consumes their lookup and read results.
- Policy: write-back, write-allocate. 8-bit addresses, 8-bit words.

Parameters:
RAM_TIMEOUT, 16, max cycles waiting for ram_ack in WB/FETCH before aborting (legal 2..255)
CNT_W, 8, width of saturating hit/miss counters

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-high
cpu_req  in  1  access request, sampled only in IDLE
cpu_write  in  1  1=write, 0=read
cpu_addr  in  8  access address
cpu_wdata  in  8  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  8  read result, valid while cpu_ready=1
cpu_hit  out  1  access hit in cache, valid with cpu_ready
busy  out  1  state != IDLE
cache_lookup  out  1  high for the LOOKUP cycle
cache_hit  in  1  cache lookup result (combinational during LOOKUP)
cache_hit_way  in  1  way that hit
cache_rdata  in  8  data of hit line
victim_way  in  1  way chosen for replacement (invalid first, else LRU)
victim_valid  in  1  victim line valid
victim_dirty  in  1  victim line dirty
victim_tag  in  8  victim line address
victim_data  in  8  victim line data
cache_fill  out  1  one-cycle line write strobe
fill_way  out  1  way to write
fill_tag  out  8  address written to line
fill_data  out  8  data written to line
fill_dirty  out  1  dirty bit to store (valid bit always set by cache on fill)
ram_req  out  1  RAM request, held until ram_ack or timeout
ram_write  out  1  1=write-back, 0=fetch
ram_addr  out  8  RAM address
ram_wdata  out  8  write-back data
ram_ack  in  1  RAM completion; ram_rdata valid same cycle
ram_rdata  in  8  fetched word
err  out  1  sticky timeout flag, cleared only by reset
hit_count  out  CNT_W  saturating count of completed hits
miss_count  out  CNT_W  saturating count of completed misses (incl. aborted)

Behaviour:
- Reset: state=IDLE. All outputs 0, including counters, err and latched request regs. Applies mid-operation: ram_req drops the cycle after reset is sampled, and no fill or ready is issued.
- States: IDLE, LOOKUP, WB, FETCH, FILL, DONE.
- IDLE: on cpu_req=1, latch write/addr/wdata, go to LOOKUP. cpu_req is ignored in every other state; no queuing.
- LOOKUP (cache_lookup=1, one cycle), sampling the cache_* and victim_* inputs:
  - Read hit: cpu_rdata<=cache_rdata, hit=1, go to DONE.
  - Write hit: way<=cache_hit_way, hit=1, go to FILL.
  - Miss with victim_valid & victim_dirty: latch victim tag/data/way, go to WB.
  - Other miss, write: go to FILL. Write-allocate, no fetch.
  - Other miss, read: go to FETCH.
- WB:
  - Drive ram_req=1, ram_write=1, ram_addr=victim_tag, ram_wdata=victim_data.
  - On ram_ack: read goes to FETCH, write goes to FILL.
- FETCH:
  - Drive ram_req=1, ram_write=0, ram_addr=latched addr.
  - On ram_ack: capture ram_rdata, go to FILL.
- Timeout counter:
  - Cleared on entry to WB and to FETCH; increments each cycle without ack.
  - At count==RAM_TIMEOUT-1 with no ack: set err, cpu_rdata=0, hit=0, go to DONE. No fill; the victim is left untouched.
- FILL (cache_fill=1, one cycle):
  - fill_way = hit way or victim way; fill_tag = latched addr.
  - fill_data = wdata on write, fetched word on read.
  - fill_dirty = cpu_write.
  - cpu_rdata <= fill_data on read. Go to DONE.
- DONE: cpu_ready=1, cpu_hit valid. Increment hit_count or miss_count, saturating at all-ones. Go to IDLE.
- Latency, counted from the cycle after cpu_req is sampled:
  - Read hit: ready 2 cycles later.
  - Write hit: 3 cycles.
  - Clean write miss: 3 cycles.
  - Clean read miss: 4 + ack wait.
  - Dirty read miss: 5 + both ack waits.
- ram_ack outside WB/FETCH is ignored. ram_ack arriving in the same cycle as the timeout limit wins (it is a normal completion).
- Strobes cache_lookup, cache_fill and cpu_ready are registered single-cycle pulses. ram_* outputs are registered and stable while ram_req=1.

Test Plan:
- Reset, then read addr 0x64 with cache_hit=1, cache_rdata=0x05 -> cache_lookup pulse next cycle; cpu_ready=1 two cycles after req with cpu_rdata=0x05, cpu_hit=1, hit_count=1, no ram_req.
- Read 0x66 with a miss and clean victim (way 1); ram_ack after 3 cycles with ram_rdata=0x01 -> one ram_req read at ram_addr=0x66; cache_fill with fill_way=1, tag=0x66, data=0x01, fill_dirty=0; cpu_rdata=0x01, cpu_hit=0, miss_count=1.
- Write 0x67 data 0xAA with a miss and dirty victim tag=0x65, data=0x03 -> WB: ram_write=1, addr=0x65, wdata=0x03 until ack; then fill tag=0x67, data=0xAA, dirty=1; no fetch issued.
- Read miss with ram_ack never asserted, RAM_TIMEOUT=16 -> ram_req high for exactly 16 cycles; err=1; cpu_ready with cpu_rdata=0x00; no cache_fill; err stays set across later requests.
- Assert reset during FETCH -> ram_req=0 and busy=0 the next cycle; counters 0; no cpu_ready. cpu_req pulsed while busy is ignored, and exactly one completion is seen per accepted request.
- 300 consecutive read hits -> hit_count saturates at 255, miss_count=0.
